mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage directly downstream of the register file; consumes the two read-port values (outA, outB) as srcA/srcB.
- Serves MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO. Holds off dependent instructions via busy.
- Radix-2, one bit per cycle; MFHI/MFLO read hi/lo combinationally downstream.

Parameters:
- WIDTH, 32, operand width. HI/LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rstN  input  1  asynchronous active-low reset
- start  input  1  issue request; accepted only when busy=0
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (ignored)
- srcA  input  WIDTH  rs value (multiplicand/dividend/MTHI-MTLO data)
- srcB  input  WIDTH  rt value (multiplier/divisor)
- cancel  input  1  pipeline flush; aborts in-flight op
- busy  output  1  high while MUL/DIV/FIXUP in progress
- done  output  1  one-cycle pulse when HI/LO updated by mul/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Interface: one clock, clk; reset rstN is asynchronous, active-low.
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, iteration counter 0, operand latches 0.
- States:
  - IDLE: start=1, busy=0, cancel=0 at edge E0 → latch |srcA|, |srcB| (signed ops) or raw values (unsigned ops); record signs; go to MUL (op 0/1) or DIV (op 2/3).
  - MUL: one shift-add per edge; counter 0..WIDTH-1; exit to FIXUP after counter==WIDTH-1.
  - DIV: restoring division, one quotient bit per edge; same counter and exit rule.
  - FIXUP: one edge; apply sign correction; write hi/lo; register done=1; return to IDLE.
- MTHI/MTLO in IDLE: hi (or lo) <= srcA at E0; no busy, no done; state stays IDLE.
- Latency (default): busy=1 for exactly WIDTH+1 cycles after E0. hi/lo new values and done=1 appear in the same cycle busy falls.
- hi/lo hold their old values throughout MUL/DIV; they change only at FIXUP or MTHI/MTLO.
- start while busy=1 (any op, including MTHI/MTLO): ignored, no effect. Issue logic must stall on busy.
- Reserved op with start: ignored.
- Signed multiply: product = sign(A)^sign(B) ? -(|A|*|B|) : |A|*|B|; HI = upper WIDTH bits, LO = lower WIDTH bits.
- Signed divide:
  - quotient sign = sign(A)^sign(B); remainder sign = sign(A).
  - LO = quotient, HI = remainder; truncation toward zero.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000, no error.
- Divide by zero (DIV or DIVU): full-length latency; LO=all ones, HI=srcA as latched (original signed value, not its magnitude).
- cancel in MUL/DIV/FIXUP: state → IDLE at next edge; busy=0 next cycle; hi/lo unchanged; no done.
- cancel and start both high in IDLE: cancel wins; op ignored, including MTHI/MTLO.
- rstN asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: MUL exits to FIXUP as soon as the remaining unprocessed multiplier bits are all zero. MUL cycles = max(1, msbIndex(|B|)+1); busy length = MUL cycles + 1. DIV is unaffected. Results are identical to the default build.
- Undefined: MUL always runs WIDTH cycles.

Test Plan:
- Reset: assert rstN=0 mid-MULTU → hi=lo=0, busy=0, done=0 immediately. Release → start accepted on next cycle.
- MULTU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF → busy high 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001, done high 1 cycle.
- MULT srcA=0xFFFFFFFD (-3), srcB=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Divides:
  - DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/0 → LO=0xFFFFFFFF, HI=0x00000007.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTLO 0xCAFEBABE in IDLE → lo=0xCAFEBABE next cycle, done=0. Then start MULTU; at cycle 10 issue MTHI 0x1234 (ignored); at cycle 12 assert cancel → busy=0 next cycle, hi/lo unchanged (lo=0xCAFEBABE), no done.
- With MDU_EARLY_OUT_EN: MULTU 5*3 → busy 3 cycles, LO=15, HI=0. MULTU 2*0 → busy 2 cycles, HI=LO=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 iterative MIPS multiply/divide unit with HI/LO registers.
// Define MDU_EARLY_OUT_EN to let MUL stop once the remaining multiplier bits are zero.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, md_q, md_d, res;
    logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, q_fix, r_fix, a_abs, b_abs;
    logic neg_q, neg_d, rneg_q, rneg_d, is_div_q, is_div_d, done_q, done_d;
    logic [WIDTH:0] shl, trial;
    logic sgn, last, mul_last;

    assign last = cnt_q == CW'(WIDTH - 1);
`ifdef MDU_EARLY_OUT_EN
    assign mul_last = last || (b_q[WIDTH-1:1] == '0);
`else
    assign mul_last = last;
`endif
    // Division keeps {remainder, dividend/quotient} in acc; MUL keeps the running product.
    assign shl   = acc_q[2*WIDTH-1:WIDTH-1];
    assign trial = shl - {1'b0, b_q};
    assign res   = neg_q ? -acc_q : acc_q;
    assign q_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign r_fix = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign sgn   = ~op[0];
    assign a_abs = (sgn && srcA[WIDTH-1]) ? -srcA : srcA;
    assign b_abs = (sgn && srcB[WIDTH-1]) ? -srcB : srcB;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        md_d     = md_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        done_d   = 1'b0;
        if (cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    if (op[2] == 1'b0) begin
                        md_d     = {{WIDTH{1'b0}}, a_abs};
                        b_d      = b_abs;
                        acc_d    = op[1] ? {{WIDTH{1'b0}}, a_abs} : '0;
                        neg_d    = sgn & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        rneg_d   = sgn & srcA[WIDTH-1];
                        is_div_d = op[1];
                        cnt_d    = '0;
                        state_d  = op[1] ? DIV : MUL;
                    end else if (op == 3'd4) begin
                        hi_d = srcA;
                    end else if (op == 3'd5) begin
                        lo_d = srcA;
                    end
                end
                MUL: begin
                    acc_d   = acc_q + (b_q[0] ? md_q : '0);
                    md_d    = md_q << 1;
                    b_d     = b_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = mul_last ? FIXUP : MUL;
                end
                DIV: begin
                    acc_d   = trial[WIDTH] ? {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                           : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last ? FIXUP : DIV;
                end
                default: begin
                    // Remainder of a divide-by-zero is |A| re-signed by A, i.e. A itself.
                    hi_d    = is_div_q ? r_fix : res[2*WIDTH-1:WIDTH];
                    lo_d    = is_div_q ? ((b_q == '0) ? '1 : q_fix) : res[WIDTH-1:0];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            md_q     <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            md_q     <= md_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            done_q   <= done_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed plus random checks of mul_div_unit against an arithmetic model.
module tb_mul_div_unit;
    localparam int WIDTH = 32;
    logic clk = 1'b0;
    logic rstN = 1'b1;
    logic start = 1'b0;
    logic [2:0] op = '0;
    logic [WIDTH-1:0] srcA = '0, srcB = '0;
    logic cancel = 1'b0;
    logic busy, done;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] exp_hi = '0, exp_lo = '0;
    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rstN(rstN), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 3'd0) begin
            p = 64'(sa * sb);
            return p;
        end
        if (o == 3'd1) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic int mul_cycles(input logic [2:0] o, input logic [31:0] b);
        logic [31:0] m;
        int c;
        m = (o == 3'd0 && b[31]) ? -b : b;
        c = 1;
        for (int i = 0; i < 32; i++) if (m[i]) c = i + 1;
        return c;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int n, exp_n;
        e = model(o, a, b);
        exp_n = WIDTH + 1;
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) exp_n = mul_cycles(o, b) + 1;
`endif
        issue(o, a, b);
        chk({tag, " busy_rise"}, 64'(busy), 64'd1);
        chk({tag, " hold"}, {hi, lo}, {exp_hi, exp_lo});
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_n));
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " result"}, {hi, lo}, e);
        {exp_hi, exp_lo} = e;
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [2:0] ro;
        logic [31:0] ra, rb;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", {62'(0), busy, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rstN = 1'b1;
        issue(3'd4, 32'h5555_AAAA, 32'h0);
        exp_hi = 32'h5555_AAAA;
        chk("mthi", {hi, lo}, {exp_hi, exp_lo});
        // Reset in the middle of a MULTU must clear everything at once.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("async_reset", {hi, lo, 30'(0), busy, done}, 96'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rstN = 1'b1;
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", 3'd3, 32'd7, 32'd0);
        chk("divu_zero_lit", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op("div_zero_neg", 3'd2, 32'h8000_0003, 32'd0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lit", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("multu_small", 3'd1, 32'd5, 32'd3);
        run_op("multu_zero", 3'd1, 32'd2, 32'd0);
        run_op("mult_minb", 3'd0, 32'd3, 32'hFFFF_FFFF);
        // MTLO, then a MULTU that ignores a late MTHI and is cancelled.
        issue(3'd5, 32'hCAFE_BABE, 32'h0);
        exp_lo = 32'hCAFE_BABE;
        chk("mtlo", {hi, lo}, {exp_hi, exp_lo});
        chk("mtlo_nodone", {62'(0), busy, done}, 64'd0);
        issue(3'd1, 32'hFFFF, 32'h1234);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 3'd4; srcA = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore", 64'(busy), 64'd1);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel", {hi, lo, 30'(0), busy, done}, {exp_hi, exp_lo, 32'd0});
        repeat (40) @(negedge clk);
        chk("cancel_quiet", {hi, lo, 30'(0), busy, done}, {exp_hi, exp_lo, 32'd0});
        start = 1'b1; cancel = 1'b1; op = 3'd4; srcA = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel_wins", {hi, lo, 30'(0), busy, done}, {exp_hi, exp_lo, 32'd0});
        start = 1'b1; op = 3'd6;
        @(negedge clk);
        start = 1'b0;
        chk("reserved", {hi, lo, 30'(0), busy, done}, {exp_hi, exp_lo, 32'd0});
        run_op("after_cancel", 3'd1, 32'h0001_0000, 32'h0001_0000);
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(0, 15));
                2: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
